// File: rtl/packed_sat_add_seq_pkg.sv
// rtl/packed_sat_add_seq_pkg.sv - shared state encoding and saturation constants
package packed_sat_add_seq_pkg;

  localparam int LANE_BITS = 8;

  localparam logic [LANE_BITS-1:0] SAT_POS = 8'h7F;
  localparam logic [LANE_BITS-1:0] SAT_NEG = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/packed_sat_add_seq_sat_add8.sv
// rtl/packed_sat_add_seq_sat_add8.sv - combinational 8-bit signed add/sub with saturation
module sat_add8
  import packed_sat_add_seq_pkg::*;
(
  input  logic [LANE_BITS-1:0] a,
  input  logic [LANE_BITS-1:0] b,
  input  logic                 sub,
  output logic [LANE_BITS-1:0] sum,
  output logic                 sat,
  output logic                 cout
);

  logic [LANE_BITS-1:0] b_eff;
  logic [LANE_BITS:0]   full;
  logic [LANE_BITS-1:0] raw;
  logic                 same_sign;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{LANE_BITS{1'b0}}, sub};
  assign raw   = full[LANE_BITS-1:0];
  assign cout  = full[LANE_BITS];

  // Compare against the sign of b itself (flipped for sub) rather than ~b+1,
  // so b=0x80 in a subtraction still counts as a negative subtrahend.
  assign same_sign = (a[LANE_BITS-1] == (b[LANE_BITS-1] ^ sub));
  assign sat       = same_sign && (raw[LANE_BITS-1] != a[LANE_BITS-1]);
  assign sum       = sat ? (a[LANE_BITS-1] ? SAT_NEG : SAT_POS) : raw;

endmodule

// File: rtl/packed_sat_add_seq.sv
// rtl/packed_sat_add_seq.sv - packed signed-byte saturating add/sub, one lane per cycle
module packed_sat_add_seq
  import packed_sat_add_seq_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op_sub,
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] result,
  output logic [LANES-1:0]        sat
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [LANES*LANE_W-1:0] a_q;
  logic [LANES*LANE_W-1:0] b_q;
  logic                    op_q;

  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_b;
  logic [LANE_W-1:0] lane_sum;
  logic              lane_sat;
  logic              unused_cout;

  assign lane_a = a_q[idx*LANE_W +: LANE_W];
  assign lane_b = b_q[idx*LANE_W +: LANE_W];

  sat_add8 u_sat_add8 (
    .a    (lane_a),
    .b    (lane_b),
    .sub  (op_q),
    .sum  (lane_sum),
    .sat  (lane_sat),
    .cout (unused_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= '0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op_sub;
            result   <= '0;
            sat      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          result[idx*LANE_W +: LANE_W] <= lane_sum;
          sat[idx]                     <= lane_sat;
          if (idx == LAST_IDX) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          // in_ready stays low here, so a new request waits one IDLE cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            idx       <= '0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packed_sat_add_seq.sv
// tb/tb_packed_sat_add_seq.sv - self-checking bench for packed_sat_add_seq
module tb_packed_sat_add_seq;

  localparam int LANES = 4;
  localparam int W     = LANES * 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             op_sub = 1'b0;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     result;
  logic [LANES-1:0] sat;

  int errors = 0;
  int checks = 0;

  packed_sat_add_seq #(.LANES(LANES), .LANE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: per-lane signed clamp(a +/- b, -128, 127).
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub,
                                output logic [W-1:0] r, output logic [LANES-1:0] s);
    r = '0;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      int x;
      int y;
      int z;
      logic [7:0] xb;
      logic [7:0] yb;
      xb = av[i*8 +: 8];
      yb = bv[i*8 +: 8];
      x = int'($signed(xb));
      y = int'($signed(yb));
      z = sub ? (x - y) : (x + y);
      if (z > 127) begin
        r[i*8 +: 8] = 8'h7F;
        s[i] = 1'b1;
      end else if (z < -128) begin
        r[i*8 +: 8] = 8'h80;
        s[i] = 1'b1;
      end else begin
        r[i*8 +: 8] = z[7:0];
      end
    end
  endfunction

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1'b1);
    a = av;
    b = bv;
    op_sub = sub;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_after_accept", in_ready, 1'b0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_release", in_ready, 1'b1);
    chk("out_valid_after_release", out_valid, 1'b0);
  endtask

  task automatic run_check(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub,
                           input string tag);
    int lat;
    logic [W-1:0] er;
    logic [LANES-1:0] es;
    model(av, bv, sub, er, es);
    accept(av, bv, sub);
    wait_done(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(LANES));
    chk({tag, "_result"}, result, er);
    chk({tag, "_sat"}, sat, es);
    release_result();
  endtask

  initial begin
    int lat;
    logic [W-1:0] er;
    logic [W-1:0] er2;
    logic [LANES-1:0] es;
    logic [LANES-1:0] es2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", result, '0);
    chk("reset_sat", sat, '0);
    rst_n = 1'b1;

    // Add, no saturation
    accept(32'h01_10_7E_00, 32'h01_F0_01_00, 1'b0);
    wait_done(lat);
    chk("add_latency", 64'(lat), 64'd4);
    chk("add_result", result, 32'h02_00_7F_00);
    chk("add_sat", sat, 4'b0000);
    release_result();

    // Saturation in both directions
    accept(32'h7F_80_50_B0, 32'h01_FF_50_B0, 1'b0);
    wait_done(lat);
    chk("addsat_result", result, 32'h7F_80_7F_80);
    chk("addsat_sat", sat, 4'b1111);
    release_result();

    // Sub, including b=0x80 with a>=0
    model(32'h00_7F_00_80, 32'h80_FF_01_01, 1'b1, er, es);
    accept(32'h00_7F_00_80, 32'h80_FF_01_01, 1'b1);
    wait_done(lat);
    chk("sub_result", result, 32'h7F_7F_FF_80);
    chk("sub_sat", sat, es);
    release_result();

    // Handshake: in_valid/out_ready in RUN ignored, DONE held stable
    model(32'h05_F6_40_C0, 32'h03_04_50_B0, 1'b1, er, es);
    accept(32'h05_F6_40_C0, 32'h03_04_50_B0, 1'b1);
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 32'h1234_5678;
    op_sub = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("run_in_ready", in_ready, 1'b0);
    wait_done(lat);
    chk("hs_latency", 64'(lat), 64'd2);
    chk("hs_result", result, er);
    chk("hs_sat", sat, es);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_result", result, er);
      chk("hold_sat", sat, es);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    release_result();

    // Back-to-back with in_valid held high
    model(32'h10_20_30_40, 32'h01_02_03_04, 1'b0, er, es);
    model(32'h80_7F_00_01, 32'h01_80_80_02, 1'b1, er2, es2);
    @(negedge clk);
    a = 32'h10_20_30_40;
    b = 32'h01_02_03_04;
    op_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'h80_7F_00_01;
    b = 32'h01_80_80_02;
    op_sub = 1'b1;
    wait_done(lat);
    chk("b2b_first_latency", 64'(lat), 64'd4);
    chk("b2b_first_result", result, er);
    chk("b2b_first_sat", sat, es);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_second_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_done(lat);
    chk("b2b_second_latency", 64'(lat), 64'd4);
    chk("b2b_second_result", result, er2);
    chk("b2b_second_sat", sat, es2);
    release_result();

    // Asynchronous reset at idx=2
    accept(32'h11_22_33_7F, 32'h01_01_01_01, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_result", result, '0);
    chk("arst_sat", sat, '0);
    chk("arst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_check(32'h9C_64_01_FF, 32'h9C_64_FF_01, 1'b0, "post_reset");

    // Random vectors
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 8 == 0) rb[7:0] = 8'h80;
      run_check(ra, rb, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
